// File: rtl/antic_dlist_sequencer_pkg.sv
// Shared definitions for the ANTIC display-list sequencer: FSM states,
// instruction field positions, mode constants and playfield width codes.
package antic_dlist_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_WAIT_VB  = 3'd0,
    ST_FETCH_IR = 3'd1,
    ST_FETCH_LO = 3'd2,
    ST_FETCH_HI = 3'd3,
    ST_EMIT     = 3'd4
  } state_t;

  // Instruction register field positions
  localparam int unsigned IR_DLI_BIT = 7;
  localparam int unsigned IR_LMS_BIT = 6;
  localparam int unsigned IR_VS_BIT  = 5;
  localparam int unsigned IR_HS_BIT  = 4;

  localparam logic [3:0] MODE_BLANK = 4'h0;
  localparam logic [3:0] MODE_JUMP  = 4'h1;

  typedef enum logic [1:0] {
    PF_OFF    = 2'b00,
    PF_NARROW = 2'b01,
    PF_NORMAL = 2'b10,
    PF_WIDE   = 2'b11
  } pf_width_t;

  // Byte-count families, named by their normal-width byte count
  typedef enum logic [1:0] {
    BW_NONE = 2'd0,
    BW_40   = 2'd1,
    BW_20   = 2'd2,
    BW_10   = 2'd3
  } byte_class_t;

  // True when the instruction carries a two-byte operand (jump or LMS)
  function automatic logic needs_operand(input logic [7:0] ir);
    return (ir[3:0] == MODE_JUMP) ||
           ((ir[3:0] >= 4'h2) && ir[IR_LMS_BIT]);
  endfunction

endpackage

// File: rtl/antic_dlist_sequencer_mode_lut.sv
// Combinational mode decoder: scan lines per instruction and memory bytes
// consumed per mode line for the current playfield width.
module antic_mode_lut
  import antic_dlist_sequencer_pkg::*;
(
  input  logic [3:0] mode,
  input  logic [2:0] ir_hi,
  input  logic [1:0] pf_width,
  output logic [4:0] lines_per_instr,
  output logic [5:0] bytes_per_line
);

  byte_class_t cls;

  // Decode line count and byte family from the mode nibble
  always_comb begin
    lines_per_instr = 5'd1;
    cls             = BW_NONE;
    case (mode)
      4'h0: lines_per_instr = {2'b00, ir_hi} + 5'd1;
      4'h1: lines_per_instr = 5'd1;
      4'h2: begin lines_per_instr = 5'd8;  cls = BW_40; end
      4'h3: begin lines_per_instr = 5'd10; cls = BW_40; end
      4'h4: begin lines_per_instr = 5'd8;  cls = BW_40; end
      4'h5: begin lines_per_instr = 5'd16; cls = BW_40; end
      4'h6: begin lines_per_instr = 5'd8;  cls = BW_20; end
      4'h7: begin lines_per_instr = 5'd16; cls = BW_20; end
      4'h8: begin lines_per_instr = 5'd8;  cls = BW_10; end
      4'h9: begin lines_per_instr = 5'd4;  cls = BW_10; end
      4'hA: begin lines_per_instr = 5'd4;  cls = BW_20; end
      4'hB: begin lines_per_instr = 5'd2;  cls = BW_20; end
      4'hC: begin lines_per_instr = 5'd1;  cls = BW_20; end
      4'hD: begin lines_per_instr = 5'd2;  cls = BW_40; end
      4'hE: begin lines_per_instr = 5'd1;  cls = BW_40; end
      default: begin lines_per_instr = 5'd1; cls = BW_40; end
    endcase
  end

  // Scale the byte family by playfield width
  always_comb begin
    bytes_per_line = '0;
    case (pf_width)
      PF_NARROW: begin
        case (cls)
          BW_40:   bytes_per_line = 6'd32;
          BW_20:   bytes_per_line = 6'd16;
          BW_10:   bytes_per_line = 6'd8;
          default: bytes_per_line = '0;
        endcase
      end
      PF_NORMAL: begin
        case (cls)
          BW_40:   bytes_per_line = 6'd40;
          BW_20:   bytes_per_line = 6'd20;
          BW_10:   bytes_per_line = 6'd10;
          default: bytes_per_line = '0;
        endcase
      end
      PF_WIDE: begin
        case (cls)
          BW_40:   bytes_per_line = 6'd48;
          BW_20:   bytes_per_line = 6'd24;
          BW_10:   bytes_per_line = 6'd12;
          default: bytes_per_line = '0;
        endcase
      end
      default: bytes_per_line = '0;
    endcase
  end

endmodule

// File: rtl/antic_dlist_sequencer.sv
// ANTIC display-list sequencer: fetches instructions and operands over a
// req/ack DMA port, emits one descriptor per scan line, advances the MSR
// per mode line and raises display-list interrupts.
module antic_dlist_sequencer
  import antic_dlist_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W          = 16,
  parameter int unsigned DLIST_WRAP_BITS = 10,
  parameter int unsigned MSR_WRAP_BITS   = 12
) (
  input  logic              Fphi0,
  input  logic              RST,
  input  logic              vblank,
  input  logic [ADDR_W-1:0] dlist_start,
  input  logic [1:0]        pf_width,
  output logic              dma_req,
  output logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_ack,
  input  logic [7:0]        dma_data,
  output logic              line_valid,
  input  logic              line_rdy,
  output logic [3:0]        line_mode,
  output logic [3:0]        line_scan,
  output logic              line_last,
  output logic              line_hs,
  output logic              line_vs,
  output logic [ADDR_W-1:0] line_msr,
  output logic              dli_req,
  output logic [ADDR_W-1:0] dlist_ptr,
  output logic              idle
);

  localparam logic [ADDR_W-1:0] PTR_MASK = {ADDR_W{1'b1}} >> (ADDR_W - DLIST_WRAP_BITS);
  localparam logic [ADDR_W-1:0] MSR_MASK = {ADDR_W{1'b1}} >> (ADDR_W - MSR_WRAP_BITS);

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        op_lo_q, op_lo_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] msr_q, msr_d;
  logic [3:0]        scan_q, scan_d;
  logic              dma_req_q, dma_req_d;
  logic              line_valid_q, line_valid_d;
  logic              dli_q, dli_d;
  logic              vblank_q, vblank_d;

  logic [4:0]        lines_per_instr;
  logic [5:0]        bytes_per_line;
  logic              vb_edge, ack, accept, is_jump, scan_last;
  logic [ADDR_W-1:0] ptr_inc, msr_next, operand;

  antic_mode_lut u_mode_lut (
    .mode            (ir_q[3:0]),
    .ir_hi           (ir_q[6:4]),
    .pf_width        (pf_width),
    .lines_per_instr (lines_per_instr),
    .bytes_per_line  (bytes_per_line)
  );

  // Derived control terms shared by the next-state logic and outputs
  always_comb begin
    vb_edge   = vblank & ~vblank_q;
    ack       = dma_req_q & dma_ack;
    accept    = line_valid_q & line_rdy;
    is_jump   = (ir_q[3:0] == MODE_JUMP);
    scan_last = ({1'b0, scan_q} == (lines_per_instr - 5'd1));
    ptr_inc   = (ptr_q & ~PTR_MASK) | ((ptr_q + ADDR_W'(1)) & PTR_MASK);
    msr_next  = (msr_q & ~MSR_MASK) | ((msr_q + ADDR_W'(bytes_per_line)) & MSR_MASK);
    operand   = ADDR_W'({dma_data, op_lo_q});
  end

  // Next-state logic; a vblank rising edge overrides every other event
  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    op_lo_d      = op_lo_q;
    ptr_d        = ptr_q;
    msr_d        = msr_q;
    scan_d       = scan_q;
    dma_req_d    = dma_req_q;
    line_valid_d = line_valid_q;
    dli_d        = 1'b0;
    vblank_d     = vblank;

    if (vb_edge) begin
      ptr_d        = dlist_start;
      state_d      = ST_FETCH_IR;
      dma_req_d    = 1'b1;
      line_valid_d = 1'b0;
      scan_d       = '0;
    end else begin
      case (state_q)
        ST_WAIT_VB: begin
          dma_req_d    = 1'b0;
          line_valid_d = 1'b0;
        end
        ST_FETCH_IR: if (ack) begin
          ir_d  = dma_data;
          ptr_d = ptr_inc;
          if (needs_operand(dma_data)) begin
            state_d = ST_FETCH_LO;
          end else begin
            state_d      = ST_EMIT;
            dma_req_d    = 1'b0;
            line_valid_d = 1'b1;
            scan_d       = '0;
          end
        end
        ST_FETCH_LO: if (ack) begin
          op_lo_d = dma_data;
          ptr_d   = ptr_inc;
          state_d = ST_FETCH_HI;
        end
        ST_FETCH_HI: if (ack) begin
          if (is_jump) begin
            ptr_d = operand;
          end else begin
            msr_d = operand;
            ptr_d = ptr_inc;
          end
          state_d      = ST_EMIT;
          dma_req_d    = 1'b0;
          line_valid_d = 1'b1;
          scan_d       = '0;
        end
        ST_EMIT: if (accept) begin
          if (scan_last) begin
            line_valid_d = 1'b0;
            msr_d        = msr_next;
            dli_d        = ir_q[IR_DLI_BIT];
            if (is_jump && ir_q[IR_LMS_BIT]) begin
              state_d = ST_WAIT_VB;
            end else begin
              state_d   = ST_FETCH_IR;
              dma_req_d = 1'b1;
            end
          end else begin
            scan_d = scan_q + 4'd1;
          end
        end
        default: begin
          state_d      = ST_WAIT_VB;
          dma_req_d    = 1'b0;
          line_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge Fphi0) begin
    if (RST) begin
      state_q      <= ST_WAIT_VB;
      ir_q         <= '0;
      op_lo_q      <= '0;
      ptr_q        <= '0;
      msr_q        <= '0;
      scan_q       <= '0;
      dma_req_q    <= 1'b0;
      line_valid_q <= 1'b0;
      dli_q        <= 1'b0;
      vblank_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      ir_q         <= ir_d;
      op_lo_q      <= op_lo_d;
      ptr_q        <= ptr_d;
      msr_q        <= msr_d;
      scan_q       <= scan_d;
      dma_req_q    <= dma_req_d;
      line_valid_q <= line_valid_d;
      dli_q        <= dli_d;
      vblank_q     <= vblank_d;
    end
  end

  // Outputs; request and valid are masked in the vblank edge cycle so an
  // in-flight fetch or descriptor is withdrawn immediately
  always_comb begin
    dma_req    = dma_req_q & ~vb_edge;
    dma_addr   = ptr_q;
    line_valid = line_valid_q & ~vb_edge;
    line_mode  = (line_valid_q && !is_jump) ? ir_q[3:0] : MODE_BLANK;
    line_scan  = line_valid_q ? scan_q : '0;
    line_last  = line_valid_q & scan_last;
    line_hs    = line_valid_q & ir_q[IR_HS_BIT];
    line_vs    = line_valid_q & ir_q[IR_VS_BIT];
    line_msr   = line_valid_q ? msr_q : '0;
    dli_req    = dli_q;
    dlist_ptr  = ptr_q;
    idle       = (state_q == ST_WAIT_VB);
  end

endmodule

// File: tb/tb_antic_dlist_sequencer.sv
// Bench for antic_dlist_sequencer: an instruction-level display-list model
// predicts fetch addresses, descriptors and DLI pulses; a per-cycle compare
// process checks the DUT against it, plus directed literal checks.
module tb_antic_dlist_sequencer;

  logic        Fphi0 = 1'b0;
  logic        RST, vblank, dma_ack, line_rdy;
  logic [15:0] dlist_start;
  logic [1:0]  pf_width;
  logic [7:0]  dma_data;
  logic        dma_req, line_valid, line_last, line_hs, line_vs, dli_req, idle;
  logic [15:0] dma_addr, line_msr, dlist_ptr;
  logic [3:0]  line_mode, line_scan;

  always #5 Fphi0 = ~Fphi0;

  antic_dlist_sequencer #(.ADDR_W(16), .DLIST_WRAP_BITS(10), .MSR_WRAP_BITS(12)) dut (
    .Fphi0(Fphi0), .RST(RST), .vblank(vblank), .dlist_start(dlist_start),
    .pf_width(pf_width), .dma_req(dma_req), .dma_addr(dma_addr),
    .dma_ack(dma_ack), .dma_data(dma_data), .line_valid(line_valid),
    .line_rdy(line_rdy), .line_mode(line_mode), .line_scan(line_scan),
    .line_last(line_last), .line_hs(line_hs), .line_vs(line_vs),
    .line_msr(line_msr), .dli_req(dli_req), .dlist_ptr(dlist_ptr), .idle(idle)
  );

  typedef struct packed {
    logic [3:0]  mode;
    logic [3:0]  scan;
    logic        last;
    logic        hs;
    logic        vs;
    logic [15:0] msr;
    logic        dli;
  } line_t;

  typedef struct packed {
    logic [15:0] addr;
    logic        is_ir;
    logic [15:0] ptr_after;
  } fetch_t;

  logic [7:0]  mem [0:65535];
  line_t       exp_lines [$];
  fetch_t      exp_fetch [$];
  logic [15:0] fetch_log [$];
  logic [15:0] msr_m, ptr_m;
  int          checks = 0, failures = 0;
  int          lines_acc = 0, dli_seen = 0, stall_seen = 0;
  int unsigned lat = 0, wait_cnt = 0, stall_left = 0;
  logic        manual = 1'b0, chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- specification-level model ----------------
  function automatic logic [15:0] inc_ptr(input logic [15:0] p);
    return {p[15:10], p[9:0] + 10'd1};
  endfunction

  function automatic logic has_operand(input logic [7:0] ir);
    return (ir[3:0] == 4'h1) || (ir[3:0] >= 4'h2 && ir[6]);
  endfunction

  function automatic int unsigned mode_lines(input logic [7:0] ir);
    case (ir[3:0])
      4'h0: return int'(ir[6:4]) + 1;
      4'h1: return 1;
      4'h2, 4'h4, 4'h6, 4'h8: return 8;
      4'h3: return 10;
      4'h5, 4'h7: return 16;
      4'h9, 4'hA: return 4;
      4'hB, 4'hD: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int unsigned mode_bytes(input logic [3:0] m, input logic [1:0] pf);
    int unsigned base;
    case (m)
      4'h2, 4'h3, 4'h4, 4'h5, 4'hD, 4'hE, 4'hF: base = 40;
      4'h6, 4'h7, 4'hA, 4'hB, 4'hC:             base = 20;
      4'h8, 4'h9:                               base = 10;
      default:                                  base = 0;
    endcase
    case (pf)
      2'b01:   return base * 4 / 5;
      2'b10:   return base;
      2'b11:   return base * 6 / 5;
      default: return 0;
    endcase
  endfunction

  task automatic push_fetch(input logic [15:0] a, input logic ir, input logic [15:0] after);
    fetch_t f;
    f.addr = a; f.is_ir = ir; f.ptr_after = after;
    exp_fetch.push_back(f);
  endtask

  task automatic model_frame(input logic [15:0] start);
    logic [7:0]  ir, lo, hi;
    logic [15:0] a;
    int unsigned n;
    line_t       l;
    bit          done = 0;
    ptr_m = start;
    for (int k = 0; k < 64 && !done; k++) begin
      ir = mem[ptr_m]; a = ptr_m; ptr_m = inc_ptr(ptr_m); push_fetch(a, 1'b1, ptr_m);
      if (has_operand(ir)) begin
        lo = mem[ptr_m]; a = ptr_m; ptr_m = inc_ptr(ptr_m); push_fetch(a, 1'b0, ptr_m);
        hi = mem[ptr_m]; a = ptr_m;
        if (ir[3:0] == 4'h1) ptr_m = {hi, lo};
        else begin ptr_m = inc_ptr(ptr_m); msr_m = {hi, lo}; end
        push_fetch(a, 1'b0, ptr_m);
      end
      n = mode_lines(ir);
      for (int unsigned s = 0; s < n; s++) begin
        l.mode = (ir[3:0] == 4'h1) ? 4'h0 : ir[3:0];
        l.scan = 4'(s);
        l.last = (s == n - 1);
        l.hs = ir[4]; l.vs = ir[5]; l.msr = msr_m;
        l.dli = ir[7] && (s == n - 1);
        exp_lines.push_back(l);
      end
      msr_m = {msr_m[15:12], 12'(msr_m[11:0] + 12'(mode_bytes(ir[3:0], pf_width)))};
      if (ir[3:0] == 4'h1 && ir[6]) done = 1;
    end
  endtask

  // ---------------- DMA responder and downstream ready ----------------
  always @(posedge Fphi0) begin
    #2;
    if (!manual) begin
      if (dma_req) begin
        if (wait_cnt >= lat) begin dma_ack = 1'b1; dma_data = mem[dma_addr]; wait_cnt = 0; end
        else begin dma_ack = 1'b0; wait_cnt++; end
      end else begin
        dma_ack = 1'b0; wait_cnt = 0;
      end
    end
    if (stall_left > 0 && line_valid && line_mode == 4'h2 && line_scan == 4'd3 && line_msr == 16'h4028) begin
      line_rdy = 1'b0; stall_left--;
    end else line_rdy = 1'b1;
  end

  // ---------------- per-cycle compare against the model ----------------
  logic        dli_exp = 1'b0, lv_exp = 1'b0, ptr_chk = 1'b0, stall_prev = 1'b0;
  logic [15:0] ptr_exp;
  logic [27:0] snap;
  line_t       el;
  fetch_t      ef;

  always @(negedge Fphi0) begin
    if (chk_en) begin
      chk("dli_req", dli_req, dli_exp);
      if (dli_req) dli_seen++;
      dli_exp = 1'b0;
      if (lv_exp) chk("line_valid_after_ack", line_valid, 1'b1);
      lv_exp = 1'b0;
      if (ptr_chk) chk("dlist_ptr_after_ack", dlist_ptr, ptr_exp);
      ptr_chk = 1'b0;
      if (stall_prev) begin
        chk("stall_stable", {line_valid, line_mode, line_scan, line_last, line_hs, line_vs, line_msr}, snap);
        stall_seen++;
      end
      if (dma_req && dma_ack) begin
        fetch_log.push_back(dma_addr);
        if (exp_fetch.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_fetch actual=%0h expected=none", dma_addr);
        end else begin
          ef = exp_fetch.pop_front();
          chk("dma_addr", dma_addr, ef.addr);
          ptr_chk = 1'b1; ptr_exp = ef.ptr_after;
          if (ef.is_ir && !has_operand(dma_data)) lv_exp = 1'b1;
        end
      end
      if (line_valid && line_rdy) begin
        lines_acc++;
        if (exp_lines.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_line actual=%0h expected=none", {line_mode, line_scan});
        end else begin
          el = exp_lines.pop_front();
          chk("line_desc", {line_mode, line_scan, line_last, line_hs, line_vs, line_msr},
              {el.mode, el.scan, el.last, el.hs, el.vs, el.msr});
          if (el.dli) dli_exp = 1'b1;
        end
      end
      stall_prev = line_valid && !line_rdy;
      snap = {line_valid, line_mode, line_scan, line_last, line_hs, line_vs, line_msr};
    end else begin
      dli_exp = 1'b0; lv_exp = 1'b0; ptr_chk = 1'b0; stall_prev = 1'b0;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic start_frame(input logic [15:0] start);
    @(posedge Fphi0); #1;
    dlist_start = start; vblank = 1'b1;
    model_frame(start);
    chk_en = 1'b1;
    @(posedge Fphi0); #1;
    vblank = 1'b0;
  endtask

  task automatic wait_done(input int unsigned limit, input string name);
    int unsigned n = 0;
    do begin
      @(negedge Fphi0); n++;
    end while (!(idle && exp_lines.size() == 0 && exp_fetch.size() == 0) && n < limit);
    chk(name, (n < limit), 1'b1);
  endtask

  initial begin
    RST = 1'b1; vblank = 1'b0; dlist_start = '0; pf_width = 2'b10;
    dma_ack = 1'b0; dma_data = '0; line_rdy = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    // list A: blank x8, LMS mode 2 @4000, DLI mode 2, LMS mode E @4FF0, JVB 3C00
    mem[16'h3C00] = 8'h70;
    mem[16'h3C01] = 8'h42; mem[16'h3C02] = 8'h00; mem[16'h3C03] = 8'h40;
    mem[16'h3C04] = 8'h82;
    mem[16'h3C05] = 8'h4E; mem[16'h3C06] = 8'hF0; mem[16'h3C07] = 8'h4F;
    mem[16'h3C08] = 8'h41; mem[16'h3C09] = 8'h00; mem[16'h3C0A] = 8'h3C;
    mem[16'h3FFF] = 8'h41;
    mem[16'h5000] = 8'h42; mem[16'h5001] = 8'h00; mem[16'h5002] = 8'h60;
    mem[16'h5100] = 8'h70;
    mem[16'h5101] = 8'h41; mem[16'h5102] = 8'h00; mem[16'h5103] = 8'h51;
    msr_m = '0;

    repeat (3) @(posedge Fphi0);
    @(negedge Fphi0);
    chk("rst_outputs", {dma_req, dma_addr, line_valid, line_mode, line_scan, line_last,
                        line_hs, line_vs, line_msr, dli_req, dlist_ptr}, 64'd0);
    chk("rst_idle", idle, 1'b1);
    @(posedge Fphi0); #1 RST = 1'b0;

    // list A with one-cycle DMA latency and a 5-cycle stall on scan 3 of 0x82
    lat = 1; stall_left = 5;
    start_frame(16'h3C00);
    wait_done(3000, "frameA_timeout");
    chk("A_ptr_model", dlist_ptr, ptr_m);
    chk("A_ptr_lit", dlist_ptr, 16'h3C00);
    chk("A_msr_model_lit", msr_m, 16'h4018);
    chk("A_first_fetch", fetch_log[0], 16'h3C00);
    chk("A_fetch_count", fetch_log.size(), 11);
    chk("A_lines", lines_acc, 26);
    chk("A_dli_pulses", dli_seen, 1);
    chk("A_stall_cycles", stall_seen, 5);
    for (int i = 0; i < 20; i++) begin
      @(negedge Fphi0);
      chk("jvb_no_req", {idle, dma_req}, 2'b10);
    end

    // pointer wrap: instruction at 3FFF, operand from 3C00/3C01, zero latency
    lat = 0; fetch_log.delete(); lines_acc = 0;
    start_frame(16'h3FFF);
    wait_done(500, "wrap_timeout");
    chk("wrap_second_fetch", fetch_log[1], 16'h3C00);
    chk("wrap_jvb_ptr", dlist_ptr, 16'h4270);
    chk("wrap_lines", lines_acc, 1);

    // abort: vblank edge while the LMS low-byte fetch is pending
    @(posedge Fphi0); #1;
    chk_en = 1'b0; manual = 1'b1;
    dlist_start = 16'h5000; vblank = 1'b1;
    @(posedge Fphi0); #1;
    vblank = 1'b0; dma_ack = 1'b1; dma_data = mem[dma_addr];
    @(negedge Fphi0);
    chk("abort_ir_addr", {dma_req, dma_addr}, {1'b1, 16'h5000});
    @(posedge Fphi0); #1 dma_ack = 1'b0;
    repeat (2) @(posedge Fphi0);
    #1;
    dlist_start = 16'h5100; vblank = 1'b1; dma_ack = 1'b1; dma_data = 8'h01;
    @(negedge Fphi0);
    chk("abort_req_drop", dma_req, 1'b0);
    chk("abort_pending_addr", dma_addr, 16'h5001);
    @(posedge Fphi0); #1;
    dma_ack = 1'b0; lat = 0; manual = 1'b0;
    fetch_log.delete(); lines_acc = 0;
    model_frame(16'h5100);
    chk_en = 1'b1;
    @(negedge Fphi0);
    chk("abort_refetch", {dma_req, dma_addr, dlist_ptr}, {1'b1, 16'h5100, 16'h5100});
    @(posedge Fphi0); #1 vblank = 1'b0;
    wait_done(500, "abort_timeout");
    chk("abort_lines", lines_acc, 9);
    chk("abort_fetches", fetch_log.size(), 4);
    chk("abort_end_ptr", dlist_ptr, 16'h5100);

    // reset in the middle of EMIT
    start_frame(16'h5100);
    begin
      int unsigned n = 0;
      while (!line_valid && n < 100) begin @(negedge Fphi0); n++; end
      chk("rst_emit_reach", (n < 100), 1'b1);
    end
    @(posedge Fphi0); #1;
    chk_en = 1'b0; RST = 1'b1;
    @(posedge Fphi0);
    @(negedge Fphi0);
    chk("rst_mid_outputs", {dma_req, dma_addr, line_valid, line_mode, line_scan, line_last,
                            line_hs, line_vs, line_msr, dli_req, dlist_ptr}, 64'd0);
    chk("rst_mid_idle", idle, 1'b1);
    exp_lines.delete(); exp_fetch.delete(); msr_m = '0;
    @(posedge Fphi0); #1 RST = 1'b0;
    repeat (2) @(posedge Fphi0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/antic_dlist_sequencer.md
# antic_dlist_sequencer

Parametrised display-list sequencer for ANTIC, the next generation of the current display-list translator. It fetches display-list bytes through a request/acknowledge DMA port and decodes blank, jump, jump-and-wait-for-vblank and mode-line instructions, including load memory scan (LMS) operand fetches. It emits one handshaked descriptor per TV scan line to the downstream shifter/GTIA driver, advances the memory scan register (MSR) per mode line, and raises display-list interrupts (DLI).

## Interface
Parameters:
- ADDR_W, 16: width of all address buses.
- DLIST_WRAP_BITS, 10: low pointer bits that increment; upper bits are frozen (1K boundary).
- MSR_WRAP_BITS, 12: low MSR bits that increment; upper bits are frozen (4K boundary).

Ports (one clock; reset is synchronous and active-high, named as in the codebase):
- Fphi0  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- vblank  in  1  vertical blank level; the rising edge restarts the list.
- dlist_start  in  ADDR_W  DLIST register value, loaded on the vblank rising edge.
- pf_width  in  2  playfield width: 00 off, 01 narrow, 10 normal, 11 wide.
- dma_req  out  1  fetch request.
- dma_addr  out  ADDR_W  fetch address; stable while dma_req is high.
- dma_ack  in  1  data valid this cycle.
- dma_data  in  8  fetched byte.
- line_valid  out  1  scan-line descriptor valid.
- line_rdy  in  1  downstream accepts the descriptor.
- line_mode  out  4  mode 0–F; 0 means blank.
- line_scan  out  4  scan index within the mode line.
- line_last  out  1  final scan line of this instruction.
- line_hs  out  1  IR[4] pass-through.
- line_vs  out  1  IR[5] pass-through.
- line_msr  out  ADDR_W  MSR for this line.
- dli_req  out  1  one-cycle DLI pulse.
- dlist_ptr  out  ADDR_W  current display-list pointer.
- idle  out  1  high in WAIT_VB.

## Operation
- States: WAIT_VB, FETCH_IR, FETCH_LO, FETCH_HI, EMIT.
- Reset: every output is 0, including dlist_ptr and MSR. State is WAIT_VB with idle=1.
- Vblank rising edge, in any state:
  - Set dlist_ptr to dlist_start and go to FETCH_IR.
  - Drop line_valid and any pending dma_req; a pending fetch's data is discarded.
  - Vblank has priority over every simultaneous event.
- Pointer increment: each acknowledged fetch increments the low DLIST_WRAP_BITS of dlist_ptr; those bits wrap to 0.
- FETCH_IR: IR is captured on dma_ack.
  - IR[3:0]=1 (jump): go to FETCH_LO.
  - IR[3:0]≥2 with IR[6]=1 (LMS): go to FETCH_LO.
  - Otherwise: go to EMIT.
- FETCH_LO / FETCH_HI: load the operand into the jump target or the MSR, low byte first.
  - Jump: after FETCH_HI, the full dlist_ptr is loaded from the operand (no wrap masking).
- Scan lines per instruction:
  - Mode 0: IR[6:4]+1.
  - Jump: 1, emitted as mode 0.
  - Modes 2/3/4/5/6/7/8/9/A/B/C/D/E/F: 8/10/8/16/8/16/8/4/4/2/1/2/1/1.
- Bytes per mode line, indexed narrow/normal/wide:
  - Modes 2–5 and D–F: 32/40/48.
  - Modes 6, 7 and A–C: 16/20/24.
  - Modes 8, 9: 8/10/12.
  - Mode 0, jump, or pf_width=00: 0.
- EMIT: present scan indices 0..N-1, advancing only on line_valid && line_rdy.
  - On acceptance of the last line:
    - MSR += bytes. Only the low MSR_WRAP_BITS add; they wrap.
    - Pulse dli_req if IR[7]=1 (also honoured for mode 0 and jump).
  - Next state after the last line:
    - Jump with IR[6]=1 (JVB): WAIT_VB.
    - Otherwise: FETCH_IR.
- Modes 2–F with IR[6]=0 keep the current MSR.

## Timing
- dma_req rises the cycle a fetch state is entered. It is held with a constant dma_addr until dma_ack.
- dma_ack may arrive in the same cycle as dma_req.
- Ack at cycle t:
  - The next state is entered at t+1.
  - For a plain mode, line_valid=1 at t+1.
- While line_rdy=0, all line_* outputs stay stable.
- The next descriptor, or the next state, follows one cycle after acceptance.
- dli_req and the MSR update take effect in the cycle after the last acceptance.
- dlist_ptr updates in the cycle after each ack.

## Structure
- Shared header ANTIC_dlistDef.v holds:
  - state encodings;
  - instruction field positions (DLI bit 7, LMS bit 6, VS bit 5, HS bit 4);
  - mode constants;
  - pf_width encodings.
- Sub-module antic_mode_lut: combinational mode + IR[6:4] + pf_width → lines_per_instr and bytes_per_line.

## Test plan
- Blank lines, no DLI:
  - Stimulus: reset; vblank with dlist_start=0x3C00; byte 0x70.
  - Response: one fetch at 0x3C00; 8 mode-0 lines with scan 0..7; line_last only on scan 7; dlist_ptr=0x3C01.
- LMS with mode 2:
  - Stimulus: pf_width=10; bytes 0x42, 0x00, 0x40.
  - Response: three fetches; line_msr=0x4000; 8 lines; MSR afterwards=0x4028.
- MSR and pointer wrap:
  - Stimulus 1: MSR=0x4FF0 with one mode-E normal line.
  - Response 1: MSR=0x4018.
  - Stimulus 2: fetch at dlist_ptr=0x3FFF.
  - Response 2: dlist_ptr=0x3C00.
- JVB:
  - Stimulus: bytes 0x41, 0x00, 0x3C.
  - Response: one blank line; dlist_ptr=0x3C00; idle=1; no dma_req until the next vblank edge.
- DLI and stall:
  - Stimulus: byte 0x82; line_rdy held low for 5 cycles on scan 3.
  - Response: line_* outputs stable during the stall; a single dli_req pulse one cycle after the 8th acceptance.
- Abort and reset:
  - Stimulus 1: vblank edge with dma_req pending.
  - Response 1: request drops, late ack data ignored, refetch from dlist_start.
  - Stimulus 2: RST mid-EMIT.
  - Response 2: all outputs 0 and WAIT_VB on the next cycle.
